// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared state encoding, coin values and game limits for the Mastermind controller
package mastermind_pkg;
  typedef enum logic [2:0] {IDLE, PLAY, GRADE, CHECK, DONE} state_e;
  localparam logic [1:0] COIN_NONE     = 2'd0;
  localparam logic [1:0] COIN_CIRCLE   = 2'd1;
  localparam logic [1:0] COIN_TRIANGLE = 2'd2;
  localparam logic [1:0] COIN_PENTAGON = 2'd3;
  localparam int GAME_COST  = 4;
  localparam int MAX_ROUNDS = 8;
  localparam int MAX_GAMES  = 7;
endpackage

// File: rtl/mastermind_game_ctrl_if.sv
// mastermind_game_ctrl_if: keys, grader handshake and display/readout signals of the game controller
interface mastermind_game_ctrl_if;
  logic [1:0]  coinValue;
  logic        coinInserted_N;
  logic        startGame_N;
  logic        gradeIt_N;
  logic [11:0] guess;
  logic        gradeAck;
  logic [3:0]  znarlyIn;
  logic [3:0]  zoodIn;
  logic        gradeReq;
  logic [11:0] guessOut;
  logic [3:0]  numGames;
  logic [3:0]  roundNumber;
  logic [3:0]  znarly;
  logic [3:0]  zood;
  logic        gameWon;
  logic        masterLoadEn;
  logic        displayMasterPattern;
  logic        loadNumGames;
  logic        loadGuess;
  logic        loadZnarlyZood;
  logic        clearGame;
  modport master (
    output coinValue, coinInserted_N, startGame_N, gradeIt_N, guess, gradeAck, znarlyIn, zoodIn,
    input  gradeReq, guessOut, numGames, roundNumber, znarly, zood, gameWon, masterLoadEn,
           displayMasterPattern, loadNumGames, loadGuess, loadZnarlyZood, clearGame
  );
  modport slave (
    input  coinValue, coinInserted_N, startGame_N, gradeIt_N, guess, gradeAck, znarlyIn, zoodIn,
    output gradeReq, guessOut, numGames, roundNumber, znarly, zood, gameWon, masterLoadEn,
           displayMasterPattern, loadNumGames, loadGuess, loadZnarlyZood, clearGame
  );
endinterface

// File: rtl/mastermind_game_ctrl_key_sync_edge.sv
// key_sync_edge: two-flop synchronizer plus registered falling-edge pulse for an active-low key
module key_sync_edge (
  input  logic CLOCK_50,
  input  logic reset_N,
  input  logic key_n_i,
  output logic ev_o
);
  logic [2:0] sh_q;
  logic       ev_q;
  // sh_q[1:0] synchronize, sh_q[2] remembers the previous synchronized level
  always_ff @(posedge CLOCK_50 or negedge reset_N) begin
    if (!reset_N) begin
      sh_q <= '1;
      ev_q <= 1'b0;
    end else begin
      sh_q <= {sh_q[1:0], key_n_i};
      ev_q <= sh_q[2] & ~sh_q[1];
    end
  end
  assign ev_o = ev_q;
endmodule

// File: rtl/mastermind_game_ctrl.sv
// mastermind_game_ctrl: coin credit, game/round sequencing and grader handshake for Mastermind
module mastermind_game_ctrl
  import mastermind_pkg::*;
#(
  parameter int MAX_ROUNDS = mastermind_pkg::MAX_ROUNDS,
  parameter int GAME_COST  = mastermind_pkg::GAME_COST,
  parameter int MAX_GAMES  = mastermind_pkg::MAX_GAMES
) (
  input logic CLOCK_50,
  input logic reset_N,
  mastermind_game_ctrl_if.slave ifc
);
  logic coin_ev, start_ev, grade_ev, start_ok;
  logic [2:0] sum, credit_q, credit_d;
  logic earn;
  logic [3:0] games_c, num_games_q, num_games_d, round_q, znarly_q, zood_q;
  logic [11:0] guess_q;
  logic grade_req_q, won_q, disp_q, master_load_q, load_num_q, load_guess_q, load_zz_q, clear_q;
  state_e state_q;
  key_sync_edge u_coin  (.CLOCK_50, .reset_N, .key_n_i(ifc.coinInserted_N), .ev_o(coin_ev));
  key_sync_edge u_start (.CLOCK_50, .reset_N, .key_n_i(ifc.startGame_N),    .ev_o(start_ev));
  key_sync_edge u_grade (.CLOCK_50, .reset_N, .key_n_i(ifc.gradeIt_N),      .ev_o(grade_ev));
  // coin credit lands first so a game earned this cycle can be started this cycle
  always_comb begin
    sum         = credit_q + {1'b0, coin_ev ? ifc.coinValue : 2'd0};
    earn        = sum >= 3'(GAME_COST);
    credit_d    = earn ? sum - 3'(GAME_COST) : sum;
    games_c     = earn && num_games_q != 4'(MAX_GAMES) ? num_games_q + 4'd1 : num_games_q;
    start_ok    = start_ev && (state_q == IDLE || state_q == DONE) && games_c != 4'd0;
    num_games_d = start_ok ? games_c - 4'd1 : games_c;
  end
  always_ff @(posedge CLOCK_50 or negedge reset_N) begin
    if (!reset_N) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      num_games_q   <= '0;
      round_q       <= '0;
      znarly_q      <= '0;
      zood_q        <= '0;
      guess_q       <= '0;
      grade_req_q   <= 1'b0;
      won_q         <= 1'b0;
      disp_q        <= 1'b0;
      master_load_q <= 1'b0;
      load_num_q    <= 1'b0;
      load_guess_q  <= 1'b0;
      load_zz_q     <= 1'b0;
      clear_q       <= 1'b0;
    end else begin
      credit_q      <= credit_d;
      num_games_q   <= num_games_d;
      load_num_q    <= start_ok || games_c != num_games_q;
      load_guess_q  <= 1'b0;
      load_zz_q     <= 1'b0;
      clear_q       <= 1'b0;
      master_load_q <= 1'b0;
      if (start_ok) begin
        state_q <= PLAY;
        round_q <= 4'd1;
        clear_q <= 1'b1;
        won_q   <= 1'b0;
        disp_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: master_load_q <= 1'b1;
          PLAY: if (grade_ev) begin
            guess_q      <= ifc.guess;
            load_guess_q <= 1'b1;
            grade_req_q  <= 1'b1;
            state_q      <= GRADE;
          end
          GRADE: if (ifc.gradeAck) begin
            znarly_q    <= ifc.znarlyIn;
            zood_q      <= ifc.zoodIn;
            load_zz_q   <= 1'b1;
            grade_req_q <= 1'b0;
            state_q     <= CHECK;
          end
          CHECK: if (znarly_q == 4'd4 || round_q == 4'(MAX_ROUNDS)) begin
            won_q   <= znarly_q == 4'd4;
            disp_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
            state_q <= PLAY;
          end
          DONE: if (start_ev) begin
            state_q       <= IDLE;
            round_q       <= '0;
            won_q         <= 1'b0;
            disp_q        <= 1'b0;
            master_load_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign ifc.gradeReq             = grade_req_q;
  assign ifc.guessOut             = guess_q;
  assign ifc.numGames             = num_games_q;
  assign ifc.roundNumber          = round_q;
  assign ifc.znarly               = znarly_q;
  assign ifc.zood                 = zood_q;
  assign ifc.gameWon              = won_q;
  assign ifc.masterLoadEn         = master_load_q;
  assign ifc.displayMasterPattern = disp_q;
  assign ifc.loadNumGames         = load_num_q;
  assign ifc.loadGuess            = load_guess_q;
  assign ifc.loadZnarlyZood       = load_zz_q;
  assign ifc.clearGame            = clear_q;
endmodule
